// File: rtl/and_gate_pkg.sv
// Shared defaults for the and_gate library cell.
// Kept separate so wrapper blocks can size their buses from the same values.
package and_gate_pkg;

    localparam int unsigned AND_GATE_DEFAULT_WIDTH = 1;
    localparam int unsigned AND_GATE_DEFAULT_CNT_W = 8;

endpackage : and_gate_pkg

// File: rtl/and_gate.sv
// Parameterised bitwise 2-input AND with a registered copy of the result
// and a saturating count of cycles in which every result bit was high.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = AND_GATE_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = AND_GATE_DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] y_q_out,
    output logic             all_ones_out,
    output logic [CNT_W-1:0] hit_cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] y_reg_d, y_reg_q;
    logic [CNT_W-1:0] hit_cnt_d, hit_cnt_q;

    // The result path never touches the clock or reset, so it stays valid during reset.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y_out[i] = a_in[i] & b_in[i];
    end

    assign all_ones_out = &y_out;

    always_comb begin
        y_reg_d   = y_out;
        hit_cnt_d = hit_cnt_q;
        if (all_ones_out && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_ONE;
        end
    end

    // NOTE: non-blocking updates keep every flop sampling pre-edge values; reset wins over counting.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            y_reg_q   <= '0;
            hit_cnt_q <= '0;
        end else begin
            y_reg_q   <= y_reg_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign y_q_out     = y_reg_q;
    assign hit_cnt_out = hit_cnt_q;

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: directed truth-table, latency, saturation and reset
// steps on two instances, followed by randomized traffic checked against a reference model.
module tb_and_gate;

    logic clk;
    logic clk_en;

    logic       rst1;
    logic [0:0] a1, b1, y1, yq1;
    logic       all1;
    logic [1:0] cnt1;

    logic       rst4;
    logic [3:0] a4, b4, y4, yq4;
    logic       all4;
    logic [7:0] cnt4;

    int checks;
    int failures;

    // reference model state (integers, saturation via min())
    int         exp_cnt1;
    int         exp_cnt4;
    logic [0:0] exp_yq1;
    logic [3:0] exp_yq4;

    and_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk_in      (clk),
        .rst_in      (rst1),
        .a_in        (a1),
        .b_in        (b1),
        .y_out       (y1),
        .y_q_out     (yq1),
        .all_ones_out(all1),
        .hit_cnt_out (cnt1)
    );

    and_gate #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk_in      (clk),
        .rst_in      (rst4),
        .a_in        (a4),
        .b_in        (b4),
        .y_out       (y4),
        .y_q_out     (yq4),
        .all_ones_out(all4),
        .hit_cnt_out (cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = clk_en ? ~clk : clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int width);
        int top;
        top = (1 << width) - 1;
        return (v + 1 > top) ? top : v + 1;
    endfunction

    // advance one rising edge, update the model from pre-edge inputs, then settle
    task automatic tick();
        @(posedge clk);
        if (rst1) begin
            exp_yq1  = '0;
            exp_cnt1 = 0;
        end else begin
            exp_yq1 = a1 & b1;
            if ((a1 & b1) == 1'b1) exp_cnt1 = sat_inc(exp_cnt1, 2);
        end
        if (rst4) begin
            exp_yq4  = '0;
            exp_cnt4 = 0;
        end else begin
            exp_yq4 = a4 & b4;
            if ((a4 & b4) == 4'hF) exp_cnt4 = sat_inc(exp_cnt4, 8);
        end
        #1;
    endtask

    task automatic chk_comb();
        chk("y1",    32'(y1),   32'(a1 & b1));
        chk("all1",  32'(all1), 32'((a1 & b1) == 1'b1));
        chk("y4",    32'(y4),   32'(a4 & b4));
        chk("all4",  32'(all4), 32'((a4 & b4) == 4'hF));
    endtask

    task automatic chk_regs();
        chk("yq1",   32'(yq1),  32'(exp_yq1));
        chk("cnt1",  32'(cnt1), 32'(exp_cnt1));
        chk("yq4",   32'(yq4),  32'(exp_yq4));
        chk("cnt4",  32'(cnt4), 32'(exp_cnt4));
    endtask

    initial begin
        logic [3:0] tt_exp;
        logic [4:0] sat_seq [5];
        checks   = 0;
        failures = 0;
        exp_cnt1 = 0;
        exp_cnt4 = 0;
        exp_yq1  = '0;
        exp_yq4  = '0;
        clk_en   = 1'b0;
        rst1     = 1'b1;
        rst4     = 1'b1;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;

        // truth table with the clock stopped
        tt_exp = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            #10;
            chk("tt_y", 32'(y1), 32'(tt_exp[i]));
            chk("tt_all", 32'(all1), 32'(tt_exp[i]));
        end

        // a zero operand forces the bit low regardless of the other one
        a1 = 1'bx; b1 = 1'b0; #10;
        chk("x_and_0", 32'(y1), 32'd0);
        a1 = 1'b0; b1 = 1'bz; #10;
        chk("0_and_z", 32'(y1), 32'd0);

        // result is live during reset while the registers are held clear
        clk_en = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        tick(); tick();
        chk("rst_y",   32'(y1),   32'd1);
        chk("rst_yq",  32'(yq1),  32'd0);
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_cnt4", 32'(cnt4), 32'd0);

        // one-cycle register latency
        rst1 = 1'b0;
        tick();
        chk("lat_yq_hi", 32'(yq1), 32'd1);
        a1 = 1'b0;
        tick();
        chk("lat_yq_lo", 32'(yq1), 32'd0);
        chk("lat_cnt",   32'(cnt1), 32'd1);

        // saturation of the 2-bit counter
        rst1 = 1'b1; tick();
        rst1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        sat_seq = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_cnt", 32'(cnt1), 32'(sat_seq[i]));
        end

        // reset in the middle of a count
        rst1 = 1'b1; tick();
        rst1 = 1'b0; tick(); tick();
        chk("mid_pre", 32'(cnt1), 32'd2);
        rst1 = 1'b1; tick();
        chk("mid_cnt", 32'(cnt1), 32'd0);
        chk("mid_yq",  32'(yq1),  32'd0);
        rst1 = 1'b0; tick();
        chk("mid_resume", 32'(cnt1), 32'd1);
        chk("mid_yq1",    32'(yq1),  32'd1);

        // multi-bit operands
        rst4 = 1'b0;
        a4 = 4'b1100; b4 = 4'b1010; #1;
        chk("mb_y",   32'(y4),   32'h8);
        chk("mb_all", 32'(all4), 32'd0);
        a4 = 4'hF; b4 = 4'hF; #1;
        chk("mb_all1", 32'(all4), 32'd1);
        tick();
        chk_regs();

        // randomized traffic, all-ones biased so the counters move, occasional resets
        for (int i = 0; i < 300; i++) begin
            a1   = 1'($urandom);
            b1   = ($urandom_range(0, 2) == 0) ? 1'($urandom) : a1;
            a4   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            b4   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : a4;
            rst1 = ($urandom_range(0, 31) == 0);
            rst4 = ($urandom_range(0, 63) == 0);
            #1;
            chk_comb();
            tick();
            chk_regs();
        end

        // long all-ones run to drive the 8-bit counter into saturation
        rst4 = 1'b1; rst1 = 1'b0;
        tick();
        rst4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
        for (int i = 0; i < 260; i++) begin
            tick();
            chk_regs();
        end
        chk("sat8_cnt", 32'(cnt4), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_and_gate
